inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/isa_pkg.sv | 27 ++
 rtl/fetch_skid_buf.sv | 82 ++++++++
 rtl/inst_fetch.sv | 64 ++++++
 tb/tb_inst_fetch.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA constants for the fetch/decode front end: widths, reset vector,
// instruction field positions and the fetch buffer occupancy encoding.
package isa_pkg;

  localparam int INST_W       = 16;
  localparam int ADDR_W       = 8;
  localparam int RESET_VECTOR = 0;

  // Decode field positions within an instruction word
  localparam int COND_HI  = 15;
  localparam int COND_LO  = 14;
  localparam int OPCD_HI  = 13;
  localparam int OPCD_LO  = 10;
  localparam int DEST_HI  = 9;
  localparam int DEST_LO  = 7;
  localparam int SRC_HI   = 6;
  localparam int SRC_LO   = 4;
  localparam int SRC2_HI  = 3;
  localparam int SRC2_LO  = 0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Output register plus one-entry skid for the fetch stage. Every input word is
// accepted; the producer guarantees it never offers a word while TWO is held.
module fetch_skid_buf
  import isa_pkg::*;
#(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         skid_valid
);

  occ_t         occ, occ_nxt;
  logic [W-1:0] skid_data;
  logic         xfer;
  logic         load_out, out_from_skid, load_skid;

  assign out_valid  = (occ != OCC_EMPTY);
  assign skid_valid = (occ == OCC_TWO);
  assign xfer       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ <= OCC_EMPTY;
    else     occ <= occ_nxt;
  end

  always_comb begin
    occ_nxt       = occ;
    load_out      = 1'b0;
    out_from_skid = 1'b0;
    load_skid     = 1'b0;
    case (occ)
      OCC_EMPTY: begin
        if (in_valid) begin
          load_out = 1'b1;
          occ_nxt  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (xfer) begin
          if (in_valid) load_out = 1'b1;
          else          occ_nxt  = OCC_EMPTY;
        end else if (in_valid) begin
          load_skid = 1'b1;
          occ_nxt   = OCC_TWO;
        end
      end
      OCC_TWO: begin
        // Skid drains first so order is preserved
        if (xfer) begin
          load_out      = 1'b1;
          out_from_skid = 1'b1;
          if (in_valid) load_skid = 1'b1;
          else          occ_nxt   = OCC_ONE;
        end
      end
      default: occ_nxt = OCC_EMPTY;
    endcase
    if (flush) begin
      occ_nxt   = OCC_EMPTY;
      load_out  = 1'b0;
      load_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      if (load_out)  out_data  <= out_from_skid ? skid_data : in_data;
      if (load_skid) skid_data <= in_data;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: registered PC into a synchronous ROM, one word in flight,
// results delivered through a skid-buffered valid/ready output with redirect.
module inst_fetch #(
  parameter int                 INST_W       = isa_pkg::INST_W,
  parameter int                 ADDR_W       = isa_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = ADDR_W'(isa_pkg::RESET_VECTOR)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target
);

  localparam int W = INST_W + ADDR_W;

  logic [ADDR_W-1:0] pc;
  logic              infl;
  logic [ADDR_W-1:0] infl_pc;
  logic              skid_valid;
  logic              issue;
  logic [W-1:0]      out_data;

  // A stalled output or an occupied skid leaves no room for the next word
  assign issue    = !skid_valid && !(inst_valid && !inst_ready);
  assign rom_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_VECTOR;
      infl    <= 1'b0;
      infl_pc <= '0;
    end else if (br_taken) begin
      pc      <= br_target;
      infl    <= 1'b0;
    end else begin
      infl <= issue;
      if (issue) begin
        pc      <= pc + 1'b1;
        infl_pc <= pc;
      end
    end
  end

  fetch_skid_buf #(.W(W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (br_taken),
    .in_valid   (infl),
    .in_data    ({infl_pc, rom_data}),
    .out_ready  (inst_ready),
    .out_valid  (inst_valid),
    .out_data   (out_data),
    .skid_valid (skid_valid)
  );

  assign {inst_pc, inst} = out_data;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized ready/redirect
// traffic, with a scoreboard of the expected in-order PC stream.
module tb_inst_fetch;

  localparam int IW = 16;
  localparam int AW = 8;
  localparam logic [AW-1:0] RV = '0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_data = '0;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_valid;
  logic          inst_ready = 1'b1;
  logic          br_taken = 1'b0;
  logic [AW-1:0] br_target = '0;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  logic [IW-1:0] rom [256];

  inst_fetch #(.INST_W(IW), .ADDR_W(AW), .RESET_VECTOR(RV)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .br_taken   (br_taken),
    .br_target  (br_target)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [AW-1:0] p, input string nm);
    int n = 0;
    while (!(inst_valid && inst_pc == p) && n < 300) begin
      step();
      n++;
    end
    chk(nm, {23'd0, inst_valid, inst_pc}, {23'd0, 1'b1, p});
  endtask

  // Scoreboard: the expected stream is tail, tail+1, ... from the last reset or
  // redirect; each transfer must consume the next entry with its ROM word.
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] tail = RV;
  logic [AW-1:0] e_pc;
  logic          held = 1'b0;
  logic [AW-1:0] held_pc;
  logic [IW-1:0] held_inst;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      tail = RV;
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 32'(inst_valid), 32'd1);
        chk("hold_pc", 32'(inst_pc), 32'(held_pc));
        chk("hold_inst", 32'(inst), 32'(held_inst));
      end
      if (inst_valid && inst_ready) begin
        e_pc = exp_q.pop_front();
        chk("sb_pc", 32'(inst_pc), 32'(e_pc));
        chk("sb_inst", 32'(inst), 32'(rom[e_pc]));
        xfers++;
      end
      held      = inst_valid && !inst_ready && !br_taken;
      held_pc   = inst_pc;
      held_inst = inst;
      if (br_taken) begin
        exp_q.delete();
        tail = br_target;
      end
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(tail);
      tail = tail + 1'b1;
    end
  end

  int x0;
  logic [AW-1:0] ra;
  logic [AW-1:0] wrap_seq [4];

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = IW'(32'h1000 + i);

    // Reset state
    repeat (3) step();
    chk("rst_rom_addr", 32'(rom_addr), 32'(RV));
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", 32'(inst), 32'd0);
    chk("rst_inst_pc", 32'(inst_pc), 32'd0);

    // Release: first issue on edge 1, valid on edge 2, then one per clk
    rst = 1'b0;
    step();
    chk("rel_e1_valid", 32'(inst_valid), 32'd0);
    chk("rel_e1_rom_addr", 32'(rom_addr), 32'd1);
    step();
    chk("rel_e2_valid", 32'(inst_valid), 32'd1);
    chk("rel_e2_pc", 32'(inst_pc), 32'd0);
    chk("rel_e2_inst", 32'(inst), 32'h1000);
    for (int i = 1; i < 5; i++) begin
      step();
      chk("stream_pc", 32'(inst_pc), 32'(i));
      chk("stream_inst", 32'(inst), 32'h1000 + 32'(i));
    end

    // Stall three cycles while 0x05 is presented
    wait_pc(8'h05, "stall_reach");
    inst_ready = 1'b0;
    ra = rom_addr;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", 32'(inst_pc), 32'h05);
      chk("stall_inst", 32'(inst), 32'h1005);
      chk("stall_rom_addr", 32'(rom_addr), 32'(ra));
    end
    inst_ready = 1'b1;
    step();
    chk("unstall_pc", 32'(inst_pc), 32'h06);

    // Redirect while the skid is full
    wait_pc(8'h10, "br_reach");
    inst_ready = 1'b0;
    step();
    step();
    br_taken  = 1'b1;
    br_target = 8'h40;
    step();
    br_taken = 1'b0;
    chk("br_valid_drop", 32'(inst_valid), 32'd0);
    inst_ready = 1'b1;
    step();
    chk("br_e1_valid", 32'(inst_valid), 32'd0);
    chk("br_e1_rom_addr", 32'(rom_addr), 32'h41);
    step();
    chk("br_e2_valid", 32'(inst_valid), 32'd1);
    chk("br_e2_pc", 32'(inst_pc), 32'h40);
    chk("br_e2_inst", 32'(inst), 32'h1040);

    // PC wraps 0xFF -> 0x00
    br_taken  = 1'b1;
    br_target = 8'hFE;
    step();
    br_taken = 1'b0;
    step();
    chk("wrap_e1_valid", 32'(inst_valid), 32'd0);
    wrap_seq[0] = 8'hFE; wrap_seq[1] = 8'hFF; wrap_seq[2] = 8'h00; wrap_seq[3] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wrap_valid", 32'(inst_valid), 32'd1);
      chk("wrap_pc", 32'(inst_pc), 32'(wrap_seq[i]));
    end

    // Asynchronous reset mid-stream with the skid full
    inst_ready = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(inst_valid), 32'd0);
    chk("arst_rom_addr", 32'(rom_addr), 32'(RV));
    step();
    rst = 1'b0;
    inst_ready = 1'b1;
    step();
    chk("rerel_e1_valid", 32'(inst_valid), 32'd0);
    step();
    chk("rerel_e2_valid", 32'(inst_valid), 32'd1);
    chk("rerel_e2_pc", 32'(inst_pc), 32'(RV));

    // Random ready / redirect traffic
    x0 = xfers;
    for (int i = 0; i < 10000; i++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      br_taken   = ($urandom_range(0, 31) == 0);
      br_target  = AW'($urandom);
      step();
    end
    br_taken   = 1'b0;
    inst_ready = 1'b1;
    repeat (6) step();
    chk("rand_progress", 32'((xfers - x0) > 2000), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
